// File: rtl/ddr4_phy_pkg.sv
// Shared DDR4 PHY types and constants for the lane read-side alignment logic.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ddr4_phy_pkg;

    localparam int SLIP_MAX = 7;
    localparam int WORD_W   = 8;

    localparam logic [WORD_W-1:0] TRAIN_PATTERN_DEF = 8'h0F;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COMPARE,
        ST_SLIP,
        ST_SETTLE,
        ST_NEXT_BIT,
        ST_DONE,
        ST_FAIL
    } rx_train_state_t;

    // Width of a bit index; a single-bit lane still needs one index bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ddr4_rx_word_cmp.sv
// Selects the word of the bit under training, compares it to the pattern, counts consecutive matches.
// Latency: match/locked combinational from rx_q; match counter updates on the next edge.
// Backpressure: none; counting only advances while cmp_en is high.
module ddr4_rx_word_cmp
    import ddr4_phy_pkg::*;
#(
    parameter int                DQ_WIDTH      = 8,
    parameter logic [WORD_W-1:0] TRAIN_PATTERN = TRAIN_PATTERN_DEF,
    parameter int                MATCH_COUNT   = 4,
    parameter int                IDX_W         = 3
) (
    input  logic                       FAB_CLK,
    input  logic                       ARST_N,
    input  logic [DQ_WIDTH*WORD_W-1:0] rx_q,
    input  logic [IDX_W-1:0]           bit_idx,
    input  logic                       cmp_en,
    input  logic                       cnt_clr,
    output logic                       match,
    output logic                       locked
);

    logic [3:0]        match_cnt;
    logic [WORD_W-1:0] word;

    assign word   = rx_q[bit_idx*WORD_W +: WORD_W];
    assign match  = (word == TRAIN_PATTERN);
    // This compare is the one that completes the run of consecutive matches.
    assign locked = cmp_en && match && (match_cnt == 4'(MATCH_COUNT - 1));

    // Consecutive-match counter: any mismatch restarts the run from zero.
    always_ff @(posedge FAB_CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            match_cnt <= '0;
        end else if (cnt_clr) begin
            match_cnt <= '0;
        end else if (cmp_en) begin
            match_cnt <= match ? match_cnt + 4'd1 : 4'd0;
        end
    end

endmodule

// File: rtl/ddr4_lane_rx_slip_align.sv
// Per-bit bit-slip training of a DQ lane's deserialised read data, then aligned read delivery.
// Latency: RX_DATA/RD_EN to RD_DATA/RD_VALID is 2 cycles; one slip decision every SETTLE_CYCLES+2 cycles.
// Backpressure: none; the read FIFO must accept every RD_VALID beat, TRAIN_START is ignored while busy.
module ddr4_lane_rx_slip_align
    import ddr4_phy_pkg::*;
#(
    parameter int                DQ_WIDTH      = 8,
    parameter logic [WORD_W-1:0] TRAIN_PATTERN = TRAIN_PATTERN_DEF,
    parameter int                MATCH_COUNT   = 4,
    parameter int                SETTLE_CYCLES = 6,
    localparam int               IDX_W         = idx_w(DQ_WIDTH)
) (
    input  logic                       FAB_CLK,
    input  logic                       ARST_N,
    input  logic                       TRAIN_START,
    input  logic                       RD_EN,
    input  logic [DQ_WIDTH*WORD_W-1:0] RX_DATA,
    output logic [DQ_WIDTH-1:0]        RX_BIT_SLIP,
    output logic                       TRAIN_BUSY,
    output logic                       TRAIN_DONE,
    output logic                       TRAIN_FAIL,
    output logic [IDX_W-1:0]           FAIL_BIT,
    output logic [DQ_WIDTH*3-1:0]      SLIP_COUNT,
    output logic [DQ_WIDTH*WORD_W-1:0] RD_DATA,
    output logic                       RD_VALID
);

    rx_train_state_t             state, state_nxt;
    logic [IDX_W-1:0]            bit_idx;
    logic [2:0]                  slip_cnt;
    logic [3:0]                  settle_cnt;
    logic [DQ_WIDTH*WORD_W-1:0]  rx_q;
    logic                        rd_en_q;
    logic                        start_ok;
    logic                        cmp_en;
    logic                        cnt_clr;
    logic                        match;
    logic                        locked;
    logic                        last_bit;

    assign start_ok = TRAIN_START &&
                      ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_FAIL));
    assign last_bit = (bit_idx == IDX_W'(DQ_WIDTH - 1));

    ddr4_rx_word_cmp #(
        .DQ_WIDTH      (DQ_WIDTH),
        .TRAIN_PATTERN (TRAIN_PATTERN),
        .MATCH_COUNT   (MATCH_COUNT),
        .IDX_W         (IDX_W)
    ) u_word_cmp (
        .FAB_CLK (FAB_CLK),
        .ARST_N  (ARST_N),
        .rx_q    (rx_q),
        .bit_idx (bit_idx),
        .cmp_en  (cmp_en),
        .cnt_clr (cnt_clr),
        .match   (match),
        .locked  (locked)
    );

    // Training FSM state register.
    always_ff @(posedge FAB_CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; the slip pulse is decoded from state so reset kills it at once.
    always_comb begin
        state_nxt   = state;
        RX_BIT_SLIP = '0;
        TRAIN_BUSY  = 1'b0;
        cmp_en      = 1'b0;
        cnt_clr     = start_ok;
        case (state)
            ST_IDLE, ST_DONE, ST_FAIL: begin
                if (TRAIN_START) state_nxt = ST_COMPARE;
            end
            ST_COMPARE: begin
                TRAIN_BUSY = 1'b1;
                cmp_en     = 1'b1;
                if (match) begin
                    if (locked) state_nxt = ST_NEXT_BIT;
                end else if (slip_cnt == 3'(SLIP_MAX)) begin
                    state_nxt = ST_FAIL;
                end else begin
                    state_nxt = ST_SLIP;
                end
            end
            ST_SLIP: begin
                TRAIN_BUSY  = 1'b1;
                RX_BIT_SLIP = DQ_WIDTH'(1) << bit_idx;
                state_nxt   = ST_SETTLE;
            end
            ST_SETTLE: begin
                TRAIN_BUSY = 1'b1;
                if (settle_cnt == 4'(SETTLE_CYCLES - 1)) state_nxt = ST_COMPARE;
            end
            ST_NEXT_BIT: begin
                TRAIN_BUSY = 1'b1;
                cnt_clr    = 1'b1;
                state_nxt  = last_bit ? ST_DONE : ST_COMPARE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Training datapath: bit index, slip/settle counters and the status outputs.
    always_ff @(posedge FAB_CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            bit_idx    <= '0;
            slip_cnt   <= '0;
            settle_cnt <= '0;
            SLIP_COUNT <= '0;
            TRAIN_DONE <= 1'b0;
            TRAIN_FAIL <= 1'b0;
            FAIL_BIT   <= '0;
        end else if (start_ok) begin
            bit_idx    <= '0;
            slip_cnt   <= '0;
            settle_cnt <= '0;
            SLIP_COUNT <= '0;
            TRAIN_DONE <= 1'b0;
            TRAIN_FAIL <= 1'b0;
            FAIL_BIT   <= '0;
        end else begin
            case (state)
                ST_COMPARE: begin
                    if (!match && (slip_cnt == 3'(SLIP_MAX))) FAIL_BIT <= bit_idx;
                end
                ST_SLIP: begin
                    slip_cnt                    <= slip_cnt + 3'd1;
                    SLIP_COUNT[bit_idx*3 +: 3]  <= slip_cnt + 3'd1;
                    settle_cnt                  <= '0;
                end
                ST_SETTLE: begin
                    settle_cnt <= settle_cnt + 4'd1;
                end
                ST_NEXT_BIT: begin
                    if (!last_bit) begin
                        bit_idx  <= bit_idx + 1'b1;
                        slip_cnt <= '0;
                    end
                end
                ST_DONE: TRAIN_DONE <= 1'b1;
                ST_FAIL: TRAIN_FAIL <= 1'b1;
                default: ;
            endcase
        end
    end

    // Read path: register RX_DATA once, then hand gated words to the read FIFO.
    always_ff @(posedge FAB_CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            rx_q     <= '0;
            rd_en_q  <= 1'b0;
            RD_DATA  <= '0;
            RD_VALID <= 1'b0;
        end else begin
            rx_q     <= RX_DATA;
            rd_en_q  <= RD_EN;
            RD_VALID <= rd_en_q && TRAIN_DONE;
            if (rd_en_q) RD_DATA <= rx_q;
        end
    end

endmodule

// File: tb/tb_ddr4_lane_rx_slip_align.sv
// Bench for ddr4_lane_rx_slip_align: an IOD model that rotates back one bit per slip pulse.
// Latency: n/a.
// Backpressure: n/a.
module tb_ddr4_lane_rx_slip_align;

    localparam int          DQ     = 8;
    localparam int          M      = 4;
    localparam int          SETTLE = 6;
    localparam logic [7:0]  PAT    = 8'h0F;

    logic          FAB_CLK = 1'b0;
    logic          ARST_N;
    logic          TRAIN_START;
    logic          RD_EN;
    logic [63:0]   RX_DATA;
    logic [7:0]    RX_BIT_SLIP;
    logic          TRAIN_BUSY;
    logic          TRAIN_DONE;
    logic          TRAIN_FAIL;
    logic [2:0]    FAIL_BIT;
    logic [23:0]   SLIP_COUNT;
    logic [63:0]   RD_DATA;
    logic          RD_VALID;

    ddr4_lane_rx_slip_align dut (
        .FAB_CLK     (FAB_CLK),
        .ARST_N      (ARST_N),
        .TRAIN_START (TRAIN_START),
        .RD_EN       (RD_EN),
        .RX_DATA     (RX_DATA),
        .RX_BIT_SLIP (RX_BIT_SLIP),
        .TRAIN_BUSY  (TRAIN_BUSY),
        .TRAIN_DONE  (TRAIN_DONE),
        .TRAIN_FAIL  (TRAIN_FAIL),
        .FAIL_BIT    (FAIL_BIT),
        .SLIP_COUNT  (SLIP_COUNT),
        .RD_DATA     (RD_DATA),
        .RD_VALID    (RD_VALID)
    );

    always #5 FAB_CLK = ~FAB_CLK;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int multi_slip = 0;
    int slip_idle  = 0;
    int rd_bad     = 0;
    bit rd_ok      = 1'b0;

    always @(posedge FAB_CLK) cyc <= cyc + 1;

    // IOD model: each bit presents PAT rotated left by its offset; a slip rotates back by one.
    logic [2:0]  ofs      [DQ];
    logic [2:0]  ofs_init [DQ];
    logic        load_ofs = 1'b0;
    bit          sens     [DQ];
    bit          stuck    [DQ];
    logic [7:0]  stuck_val[DQ];
    bit          glitch0  = 1'b0;
    bit          use_model = 1'b1;
    logic [63:0] man_data = '0;
    logic [63:0] model_data;

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] t;
        t = {x, x} << n;
        return t[15:8];
    endfunction

    always @(posedge FAB_CLK) begin
        for (int b = 0; b < DQ; b++) begin
            if (load_ofs) ofs[b] <= ofs_init[b];
            else if (RX_BIT_SLIP[b] && sens[b]) ofs[b] <= ofs[b] - 3'd1;
        end
    end

    always_comb begin
        model_data = '0;
        for (int b = 0; b < DQ; b++)
            model_data[8*b +: 8] = stuck[b] ? stuck_val[b] : rotl8(PAT, int'(ofs[b]));
        if (glitch0) model_data[7:0] = ~PAT;
    end

    assign RX_DATA = use_model ? model_data : man_data;

    // Protocol monitors on the slip strobe and the read qualifier.
    always @(negedge FAB_CLK) begin
        if (ARST_N === 1'b1) begin
            if ($countones(RX_BIT_SLIP) > 1) multi_slip++;
            if ((RX_BIT_SLIP != '0) && !TRAIN_BUSY) slip_idle++;
            if (RD_VALID && !rd_ok) rd_bad++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic load();
        @(negedge FAB_CLK) load_ofs = 1'b1;
        @(negedge FAB_CLK) load_ofs = 1'b0;
    endtask

    task automatic start_train(output int s);
        @(negedge FAB_CLK);
        TRAIN_START = 1'b1;
        s = cyc;
        @(negedge FAB_CLK);
        TRAIN_START = 1'b0;
    endtask

    // Cycles from the edge that accepts TRAIN_START to the first visible DONE/FAIL; -1 on timeout.
    task automatic wait_end(input int s, input bit rnd_rd, output int lat);
        lat = -1;
        for (int i = 0; i < 2000; i++) begin
            if (TRAIN_DONE || TRAIN_FAIL) begin
                lat = cyc - (s + 1);
                break;
            end
            @(negedge FAB_CLK);
            if (rnd_rd) RD_EN = 1'($urandom_range(0, 1));
        end
        RD_EN = 1'b0;
    endtask

    task automatic wait_slip(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge FAB_CLK);
            if (RX_BIT_SLIP != '0) begin
                seen = 1'b1;
                break;
            end
        end
        chk({tag, "_slip_seen"}, 64'(seen), 64'd1);
    endtask

    // Expected result of a successful training from the model's current offsets.
    task automatic expect_ok(input string tag, input int s, input bit rnd_rd);
        int          lat, sum;
        logic [23:0] sc;
        sum = 0;
        sc  = '0;
        for (int b = 0; b < DQ; b++) begin
            sum += int'(ofs[b]);
            sc[3*b +: 3] = ofs[b];
        end
        wait_end(s, rnd_rd, lat);
        chk({tag, "_lat"},  64'(lat), 64'(DQ*(M+1) + 1 + sum*(2+SETTLE)));
        chk({tag, "_slips"}, 64'(SLIP_COUNT), 64'(sc));
        chk({tag, "_done"}, 64'(TRAIN_DONE), 64'd1);
        chk({tag, "_fail"}, 64'(TRAIN_FAIL), 64'd0);
    endtask

    task automatic run_train(input string tag);
        int s;
        load();
        start_train(s);
        expect_ok(tag, s, 1'b0);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_slip"},  64'(RX_BIT_SLIP), 64'd0);
        chk({tag, "_busy"},  64'(TRAIN_BUSY),  64'd0);
        chk({tag, "_done"},  64'(TRAIN_DONE),  64'd0);
        chk({tag, "_fail"},  64'(TRAIN_FAIL),  64'd0);
        chk({tag, "_fbit"},  64'(FAIL_BIT),    64'd0);
        chk({tag, "_scnt"},  64'(SLIP_COUNT),  64'd0);
        chk({tag, "_rdat"},  RD_DATA,          64'd0);
        chk({tag, "_rvld"},  64'(RD_VALID),    64'd0);
    endtask

    // Read burst after DONE: each enabled word must appear 2 cycles later, gaps hold the last word.
    task automatic read_burst(input string tag, input int n, input bit fixed);
        bit          e [32];
        logic [63:0] d [32];
        logic [63:0] last_d;
        bit          has_last;
        logic [7:0]  bv;
        has_last  = 1'b0;
        last_d    = '0;
        use_model = 1'b0;
        rd_ok     = 1'b1;
        for (int i = 0; i < n + 4; i++) begin
            @(negedge FAB_CLK);
            if (i >= 2) begin
                chk({tag, "_vld"}, 64'(RD_VALID), 64'(e[i-2]));
                if (e[i-2]) begin
                    chk({tag, "_dat"}, RD_DATA, d[i-2]);
                    last_d   = d[i-2];
                    has_last = 1'b1;
                end else if (has_last) begin
                    chk({tag, "_hold"}, RD_DATA, last_d);
                end
            end
            bv   = 8'(8'h11 * (i + 1));
            e[i] = (i < n) && (fixed || ($urandom_range(0, 1) == 1));
            d[i] = fixed ? {8{bv}} : {$urandom, $urandom};
            RD_EN    = e[i];
            man_data = d[i];
        end
        RD_EN     = 1'b0;
        rd_ok     = 1'b0;
        use_model = 1'b1;
    endtask

    initial begin
        int s, lat, sum;
        ARST_N      = 1'b0;
        TRAIN_START = 1'b0;
        RD_EN       = 1'b0;
        for (int b = 0; b < DQ; b++) begin
            sens[b]      = 1'b1;
            stuck[b]     = 1'b0;
            stuck_val[b] = 8'hAA;
            ofs_init[b]  = '0;
        end
        load();
        @(negedge FAB_CLK);
        chk_reset("reset");
        ARST_N = 1'b1;

        // Zero-offset lock.
        run_train("zero");

        // Bit k offset by k rotations.
        for (int b = 0; b < DQ; b++) ofs_init[b] = 3'(b);
        run_train("stair");

        // Read path after DONE.
        read_burst("rd_fixed", 3, 1'b1);
        read_burst("rd_rand", 20, 1'b0);

        // Randomised offsets.
        for (int r = 0; r < 3; r++) begin
            for (int b = 0; b < DQ; b++) ofs_init[b] = 3'($urandom_range(0, 7));
            run_train("rand");
        end

        // Intermittent match on bit 0: glitch lands on the 4th compare, bit 0 ignores slips.
        for (int b = 0; b < DQ; b++) ofs_init[b] = '0;
        sens[0] = 1'b0;
        load();
        start_train(s);
        @(negedge FAB_CLK);
        @(negedge FAB_CLK);
        glitch0 = 1'b1;
        @(negedge FAB_CLK);
        glitch0 = 1'b0;
        wait_end(s, 1'b0, lat);
        chk("glitch_lat",   64'(lat), 64'(DQ*(M+1) + 1 + 3 + 1 + 1 + SETTLE));
        chk("glitch_slips", 64'(SLIP_COUNT), 64'd1);
        chk("glitch_done",  64'(TRAIN_DONE), 64'd1);
        sens[0] = 1'b1;

        // Unlockable bit 5, with random read gating throughout.
        stuck[5] = 1'b1;
        load();
        start_train(s);
        wait_end(s, 1'b1, lat);
        chk("stuck_lat",   64'(lat), 64'(5*(M+1) + 7*(2+SETTLE) + 2));
        chk("stuck_fail",  64'(TRAIN_FAIL), 64'd1);
        chk("stuck_done",  64'(TRAIN_DONE), 64'd0);
        chk("stuck_fbit",  64'(FAIL_BIT), 64'd5);
        chk("stuck_slips", 64'(SLIP_COUNT), 64'(24'd7 << 15));
        for (int i = 0; i < 6; i++) begin
            @(negedge FAB_CLK);
            RD_EN = 1'b1;
        end
        @(negedge FAB_CLK);
        RD_EN = 1'b0;
        repeat (3) @(negedge FAB_CLK);
        chk("stuck_rd_valid", 64'(rd_bad), 64'd0);
        chk("stuck_held", 64'(TRAIN_FAIL), 64'd1);
        stuck[5] = 1'b0;

        // TRAIN_START during SETTLE is ignored.
        for (int b = 0; b < DQ; b++) ofs_init[b] = 3'($urandom_range(0, 7));
        ofs_init[0] = 3'd3;
        load();
        sum = 0;
        start_train(s);
        wait_slip("ign");
        @(negedge FAB_CLK);
        chk("ign_busy", 64'(TRAIN_BUSY), 64'd1);
        TRAIN_START = 1'b1;
        @(negedge FAB_CLK);
        TRAIN_START = 1'b0;
        begin
            logic [23:0] sc;
            sc = '0;
            for (int b = 0; b < DQ; b++) begin
                sum += int'(ofs_init[b]);
                sc[3*b +: 3] = ofs_init[b];
            end
            wait_end(s, 1'b0, lat);
            chk("ign_lat",   64'(lat), 64'(DQ*(M+1) + 1 + sum*(2+SETTLE)));
            chk("ign_slips", 64'(SLIP_COUNT), 64'(sc));
        end

        // Reset asserted while a slip pulse is out, then retrain from scratch.
        for (int b = 0; b < DQ; b++) ofs_init[b] = 3'($urandom_range(0, 7));
        ofs_init[0] = 3'd2;
        load();
        start_train(s);
        wait_slip("arst");
        ARST_N = 1'b0;
        #1;
        chk_reset("arst");
        @(negedge FAB_CLK);
        ARST_N = 1'b1;
        chk("arst_model_ofs0", 64'(ofs[0]), 64'd2);
        start_train(s);
        expect_ok("retrain", s, 1'b0);

        chk("slip_onehot", 64'(multi_slip), 64'd0);
        chk("slip_only_busy", 64'(slip_idle), 64'd0);
        chk("rd_valid_gate", 64'(rd_bad), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
